n3l_pair_gen: RTL and testbench
===============================

# n3l_pair_gen

Sequential generator of (reference, neighbor) cell-index pairs for the half-shell (Newton's-third-law) neighbor sweep over a cubic periodic universe of UNIVERSE_SIZE³ cells. On a start pulse it walks every reference cell in linear order. For each one it emits the 14 neighbor cells that the n3l filter accepts: the cell itself plus 13 half-shell neighbors. Output is a valid/ready stream. The block sits directly upstream of the n3l_cell filter and the pair-force pipeline, so every pair it emits must make n3l_cell return 1.

## Interface
- UNIVERSE_SIZE, 3: cells per axis; legal values are ≥3.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a full sweep; sampled only in IDLE.
- pair_ready  in  1  downstream accepts the current pair.
- pair_valid  out  1  reference/neighbor hold a valid pair.
- reference  out  32  linear reference cell index.
- neighbor  out  32  linear neighbor cell index.
- pair_last_ref  out  1  current pair is the 14th (final) pair of this reference.
- pair_last  out  1  current pair is the final pair of the sweep.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the final pair's handshake.

## Operation
- Linear index: idx = x + U·y + U²·z, with x = idx%U, y = (idx/U)%U, z = idx/U²; U = UNIVERSE_SIZE.
- Reference cells are visited in order 0 … U³−1.
  - Reference coordinates (rx, ry, rz) are held as nested counters: x fastest, then y, then z.
  - No division is used.
- Offset counter k = 0 … 13 selects (dx, dy, dz) in this fixed order:
  - k=0: (0,0,0).
  - k=1…9: dx=+1; dy outer loop over −1, 0, +1; dz inner loop over −1, 0, +1.
  - k=10…12: (0,+1,−1), (0,+1,0), (0,+1,+1).
  - k=13: (0,0,+1).
- Neighbor coordinate per axis: (r + d) mod U.
  - r=U−1 with d=+1 gives 0.
  - r=0 with d=−1 gives U−1.
- FSM states:
  - IDLE: on start, clear counters and go to EMIT.
  - EMIT: present the pair. On pair_valid && pair_ready, advance k. When k=13, set k=0 and advance the reference counter. On the handshake of the final pair, go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- pair_last_ref = (k==13).
- pair_last = (k==13 && reference==U³−1).
- busy = 1 in EMIT and DONE.
- start outside IDLE is ignored. A start asserted in the DONE cycle is also ignored.
- Total pairs per sweep: 14·U³.

## Timing
- All outputs are registered.
- Reset values: pair_valid=0, reference=0, neighbor=0, pair_last_ref=0, pair_last=0, busy=0, done=0. The FSM resets to IDLE.
- start sampled high in IDLE at edge t:
  - at t+1: pair_valid=1, reference=0, neighbor=0, busy=1.
- Backpressure: with pair_ready low, all outputs hold stable and the counters do not move.
- Throughput: one pair per cycle while pair_ready stays high.
- Final handshake at edge t:
  - at t+1: pair_valid=0 and done=1.
  - at t+2: done=0, busy=0, FSM in IDLE.
  - The earliest next start is sampled at t+2.
- pair_valid never drops without a handshake, except on reset.
- rst asserted mid-sweep: outputs go to their reset values immediately (asynchronously). The sweep is abandoned and not resumed.

## Structure
- Shared package holds:
  - the cell-index width constant (32);
  - the 14-entry offset table (dx, dy, dz ∈ {−1, 0, +1}, 2-bit signed);
  - the pair count per reference (14).
- Sub-module cell_wrap: combinational (coord, 2-bit signed delta, U) → (coord + delta) mod U. Instantiate it once per axis.
- Linear-index composition (x + U·y + U²·z) stays in the top module. It is constant multiplication only.

## Test plan
- U=3, start, pair_ready=1:
  - first pair (0,0) at cycle 1;
  - pair k=1 is (0,25);
  - pair k=13 is (0,9) with pair_last_ref=1;
  - 378 pairs total, pair_last on pair 378, done one cycle later.
- U=3, reference 26:
  - k=0 → (26,26);
  - k=1 → (26,12);
  - k=13 → (26,8).
  - Checks wrap-around on all three axes.
- Random pair_ready toggling:
  - outputs hold stable while pair_ready=0;
  - the sequence is identical to the free-running run;
  - no pair is dropped or duplicated.
- Every emitted pair, U=3 and U=5, is fed to an n3l_cell reference instance:
  - o=1 for all pairs;
  - per reference, the 14 neighbors are distinct.
- start pulsed mid-sweep and again in the DONE cycle → ignored; the pair count is still 14·U³.
- rst asserted at pair 100:
  - immediately pair_valid=0 and busy=0;
  - a new start restarts from (0,0).

Source files
------------

// File: rtl/n3l_pair_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : n3l_pair_gen_pkg
// Brief    : Shared types, widths and the half-shell offset table.
// Revision : 1.0
// ============================================================================
package n3l_pair_gen_pkg;

    localparam int c_cell_w        = 32;
    localparam int c_pairs_per_ref = 14;

    typedef logic [c_cell_w-1:0] cell_idx_t;

    localparam logic signed [1:0] c_neg = 2'sb11;
    localparam logic signed [1:0] c_zro = 2'sb00;
    localparam logic signed [1:0] c_pos = 2'sb01;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
        logic signed [1:0] dz;
    } offset_t;

    // Self cell, the nine +x cells, three +y cells in the x plane, then +z.
    localparam offset_t c_offset_tbl [0:c_pairs_per_ref-1] = '{
        '{c_zro, c_zro, c_zro},
        '{c_pos, c_neg, c_neg}, '{c_pos, c_neg, c_zro}, '{c_pos, c_neg, c_pos},
        '{c_pos, c_zro, c_neg}, '{c_pos, c_zro, c_zro}, '{c_pos, c_zro, c_pos},
        '{c_pos, c_pos, c_neg}, '{c_pos, c_pos, c_zro}, '{c_pos, c_pos, c_pos},
        '{c_zro, c_pos, c_neg}, '{c_zro, c_pos, c_zro}, '{c_zro, c_pos, c_pos},
        '{c_zro, c_zro, c_pos}
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/n3l_pair_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : n3l_pair_gen_if
// Brief    : Valid/ready pair stream carrying reference/neighbor cell indices.
// Revision : 1.0
// ============================================================================
interface n3l_pair_gen_if;
    import n3l_pair_gen_pkg::*;

    logic      pair_valid;
    logic      pair_ready;
    cell_idx_t reference;
    cell_idx_t neighbor;
    logic      pair_last_ref;
    logic      pair_last;

    modport master (
        output pair_valid, reference, neighbor, pair_last_ref, pair_last,
        input  pair_ready
    );

    modport slave (
        input  pair_valid, reference, neighbor, pair_last_ref, pair_last,
        output pair_ready
    );
endinterface
`default_nettype wire

// File: rtl/n3l_pair_gen_cell_wrap.sv
`default_nettype none
// ============================================================================
// Module   : n3l_pair_gen_cell_wrap
// Brief    : Periodic single-axis step: (coord + delta) mod UNIVERSE_SIZE.
// Revision : 1.0
// ============================================================================
module n3l_pair_gen_cell_wrap
    import n3l_pair_gen_pkg::*;
#(
    parameter int UNIVERSE_SIZE = 3
) (
    input  cell_idx_t         coord,
    input  logic signed [1:0] delta,
    output cell_idx_t         wrapped
);
    localparam cell_idx_t c_max = cell_idx_t'(UNIVERSE_SIZE - 1);
    localparam cell_idx_t c_one = cell_idx_t'(1);

    always_comb begin
        wrapped = coord;
        if (delta == c_pos) begin
            wrapped = (coord == c_max) ? '0 : coord + c_one;
        end else if (delta == c_neg) begin
            wrapped = (coord == '0) ? c_max : coord - c_one;
        end
    end
endmodule
`default_nettype wire

// File: rtl/n3l_pair_gen.sv
`default_nettype none
// ============================================================================
// Module   : n3l_pair_gen
// Brief    : Half-shell (reference, neighbor) pair sweep over a periodic cube.
// Revision : 1.0
// ============================================================================
module n3l_pair_gen
    import n3l_pair_gen_pkg::*;
#(
    parameter int UNIVERSE_SIZE = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    n3l_pair_gen_if.master pair
);
    localparam cell_idx_t  c_u        = cell_idx_t'(UNIVERSE_SIZE);
    localparam cell_idx_t  c_u2       = c_u * c_u;
    localparam cell_idx_t  c_max      = c_u - cell_idx_t'(1);
    localparam cell_idx_t  c_one      = cell_idx_t'(1);
    localparam cell_idx_t  c_last_ref = c_u2 * c_u - cell_idx_t'(1);
    localparam logic [3:0] c_k_last   = 4'(c_pairs_per_ref - 1);

    state_t     r_state;
    cell_idx_t  r_rx, r_ry, r_rz;
    logic [3:0] r_k;

    cell_idx_t  w_sx, w_sy, w_sz;
    cell_idx_t  w_nx, w_ny, w_nz;
    logic [3:0] w_sk;
    offset_t    w_off;
    cell_idx_t  w_ref_idx, w_nbr_idx;
    logic       w_load;

    // Counters of the pair that will be presented after the next load.
    always_comb begin
        w_sx = r_rx;
        w_sy = r_ry;
        w_sz = r_rz;
        w_sk = r_k + 4'd1;
        if (r_state == S_IDLE) begin
            w_sx = '0;
            w_sy = '0;
            w_sz = '0;
            w_sk = '0;
        end else if (r_k == c_k_last) begin
            w_sk = '0;
            if (r_rx != c_max) begin
                w_sx = r_rx + c_one;
            end else begin
                w_sx = '0;
                if (r_ry != c_max) begin
                    w_sy = r_ry + c_one;
                end else begin
                    w_sy = '0;
                    w_sz = (r_rz == c_max) ? '0 : r_rz + c_one;
                end
            end
        end
    end

    assign w_off = c_offset_tbl[w_sk];

    n3l_pair_gen_cell_wrap #(.UNIVERSE_SIZE(UNIVERSE_SIZE)) u_wrap_x (
        .coord(w_sx), .delta(w_off.dx), .wrapped(w_nx)
    );
    n3l_pair_gen_cell_wrap #(.UNIVERSE_SIZE(UNIVERSE_SIZE)) u_wrap_y (
        .coord(w_sy), .delta(w_off.dy), .wrapped(w_ny)
    );
    n3l_pair_gen_cell_wrap #(.UNIVERSE_SIZE(UNIVERSE_SIZE)) u_wrap_z (
        .coord(w_sz), .delta(w_off.dz), .wrapped(w_nz)
    );

    assign w_ref_idx = w_sx + c_u * w_sy + c_u2 * w_sz;
    assign w_nbr_idx = w_nx + c_u * w_ny + c_u2 * w_nz;

    assign w_load = ((r_state == S_IDLE) && start) ||
                    ((r_state == S_EMIT) && pair.pair_ready && !pair.pair_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_rx               <= '0;
            r_ry               <= '0;
            r_rz               <= '0;
            r_k                <= '0;
            pair.pair_valid    <= 1'b0;
            pair.reference     <= '0;
            pair.neighbor      <= '0;
            pair.pair_last_ref <= 1'b0;
            pair.pair_last     <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            if (w_load) begin
                r_rx               <= w_sx;
                r_ry               <= w_sy;
                r_rz               <= w_sz;
                r_k                <= w_sk;
                pair.reference     <= w_ref_idx;
                pair.neighbor      <= w_nbr_idx;
                pair.pair_last_ref <= (w_sk == c_k_last);
                pair.pair_last     <= (w_sk == c_k_last) && (w_ref_idx == c_last_ref);
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state         <= S_EMIT;
                        pair.pair_valid <= 1'b1;
                        busy            <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (pair.pair_ready && pair.pair_last) begin
                        r_state            <= S_DONE;
                        pair.pair_valid    <= 1'b0;
                        pair.pair_last_ref <= 1'b0;
                        pair.pair_last     <= 1'b0;
                        done               <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_n3l_pair_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_n3l_pair_gen
// Brief    : Scoreboard bench for n3l_pair_gen at U=3 and U=5.
// Revision : 1.0
// ============================================================================
module tb_n3l_pair_gen;
    import n3l_pair_gen_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start3, start5;
    logic busy3, busy5, done3, done5;

    n3l_pair_gen_if pif3();
    n3l_pair_gen_if pif5();

    n3l_pair_gen #(.UNIVERSE_SIZE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3), .pair(pif3.master)
    );
    n3l_pair_gen #(.UNIVERSE_SIZE(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .busy(busy5), .done(done5), .pair(pif5.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        int r;
        int n;
        bit lr;
        bit l;
    } exp_t;
    exp_t exp_q[$];

    function automatic int wrap_c(input int c, input int d, input int u);
        return (c + d + u) % u;
    endfunction

    // Expected sweep built from the loop description of the offset order.
    task automatic push_sweep(input int u);
        int odx[14], ody[14], odz[14];
        int i;
        odx[0] = 0; ody[0] = 0; odz[0] = 0;
        i = 1;
        for (int dy = -1; dy <= 1; dy++)
            for (int dz = -1; dz <= 1; dz++) begin
                odx[i] = 1; ody[i] = dy; odz[i] = dz; i++;
            end
        for (int dz = -1; dz <= 1; dz++) begin
            odx[i] = 0; ody[i] = 1; odz[i] = dz; i++;
        end
        odx[13] = 0; ody[13] = 0; odz[13] = 1;
        for (int r = 0; r < u*u*u; r++) begin
            int x, y, z;
            x = r % u; y = (r / u) % u; z = r / (u*u);
            for (int k = 0; k < 14; k++) begin
                exp_t e;
                e.r  = r;
                e.n  = wrap_c(x, odx[k], u) + u*wrap_c(y, ody[k], u) + u*u*wrap_c(z, odz[k], u);
                e.lr = (k == 13);
                e.l  = (k == 13) && (r == u*u*u - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Independent half-shell acceptance test on the minimum-image offset.
    function automatic bit n3l_ok(input int r, input int n, input int u);
        int d[3];
        int rc[3], nc[3];
        rc[0] = r % u; rc[1] = (r / u) % u; rc[2] = r / (u*u);
        nc[0] = n % u; nc[1] = (n / u) % u; nc[2] = n / (u*u);
        for (int a = 0; a < 3; a++) begin
            d[a] = (nc[a] - rc[a] + u) % u;
            if (d[a] == u - 1) d[a] = -1;
            else if (d[a] > 1) return 1'b0;
        end
        return (d[0] > 0) || (d[0] == 0 && d[1] > 0) || (d[0] == 0 && d[1] == 0 && d[2] >= 0);
    endfunction

    int  n_hs3 = 0;
    int  got_nbr3[$];
    int  cur_nbrs3[$];
    bit  stall_pend = 1'b0;
    bit  done_due = 1'b0;
    logic [66:0] stall_snap;

    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
            done_due   = 1'b0;
        end else begin
            if (done_due) check_eq("done_after_last", {busy3, done3, pif3.pair_valid}, 3'b110);
            done_due = 1'b0;
            if (stall_pend)
                check_eq("hold_stable", {pif3.pair_valid, pif3.reference, pif3.neighbor,
                                         pif3.pair_last_ref, pif3.pair_last}, stall_snap);
            stall_pend = pif3.pair_valid && !pif3.pair_ready;
            stall_snap = {pif3.pair_valid, pif3.reference, pif3.neighbor,
                          pif3.pair_last_ref, pif3.pair_last};
            if (pif3.pair_valid && pif3.pair_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_pair", n_hs3, 378);
                end else begin
                    exp_t e;
                    bit dup;
                    e = exp_q.pop_front();
                    check_eq("pair", {pif3.reference, pif3.neighbor, pif3.pair_last_ref, pif3.pair_last},
                             {32'(e.r), 32'(e.n), e.lr, e.l});
                    check_eq("n3l_u3", n3l_ok(int'(pif3.reference), int'(pif3.neighbor), 3), 1);
                    if (n_hs3 % 14 == 0) cur_nbrs3.delete();
                    dup = 1'b0;
                    foreach (cur_nbrs3[j]) if (cur_nbrs3[j] == int'(pif3.neighbor)) dup = 1'b1;
                    check_eq("distinct_u3", dup, 0);
                    cur_nbrs3.push_back(int'(pif3.neighbor));
                    if (pif3.pair_last) done_due = 1'b1;
                end
                got_nbr3.push_back(int'(pif3.neighbor));
                n_hs3++;
            end
        end
    end

    int n_hs5 = 0;
    int cur_nbrs5[$];

    always @(negedge clk) begin
        if (!rst && pif5.pair_valid && pif5.pair_ready) begin
            bit dup;
            check_eq("n3l_u5", n3l_ok(int'(pif5.reference), int'(pif5.neighbor), 5), 1);
            if (n_hs5 % 14 == 0) cur_nbrs5.delete();
            dup = 1'b0;
            foreach (cur_nbrs5[j]) if (cur_nbrs5[j] == int'(pif5.neighbor)) dup = 1'b1;
            check_eq("distinct_u5", dup, 0);
            cur_nbrs5.push_back(int'(pif5.neighbor));
            n_hs5++;
        end
    end

    task automatic wait_done3(input int budget);
        int c;
        c = 0;
        while (c < budget) begin
            @(negedge clk);
            if (done3) break;
            c++;
        end
        check_eq("done3_timeout", c < budget, 1);
    endtask

    task automatic start_sweep3;
        push_sweep(3);
        n_hs3 = 0;
        got_nbr3.delete();
        @(posedge clk); #1;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        check_eq("first_pair", {pif3.pair_valid, busy3, pif3.reference, pif3.neighbor},
                 {1'b1, 1'b1, 32'd0, 32'd0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start3 = 1'b0;
        start5 = 1'b0;
        pif3.pair_ready = 1'b0;
        pif5.pair_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_vals", {pif3.pair_valid, pif3.reference, pif3.neighbor, pif3.pair_last_ref,
                                pif3.pair_last, busy3, done3}, '0);
        rst = 1'b0;

        // Free-running sweep with spot checks on wrap-around pairs.
        pif3.pair_ready = 1'b1;
        start_sweep3();
        wait_done3(1000);
        check_eq("count_free", n_hs3, 378);
        check_eq("queue_empty_free", exp_q.size(), 0);
        if (got_nbr3.size() == 378) begin
            check_eq("k1_nbr", got_nbr3[1], 25);
            check_eq("k13_nbr", got_nbr3[13], 9);
            check_eq("r26_k0", got_nbr3[364], 26);
            check_eq("r26_k1", got_nbr3[365], 12);
            check_eq("r26_k13", got_nbr3[377], 8);
        end
        @(negedge clk);
        check_eq("idle_after_done", {busy3, done3, pif3.pair_valid}, 3'b000);

        // Random backpressure plus ignored start pulses mid-sweep and in DONE.
        push_sweep(3);
        n_hs3 = 0;
        @(posedge clk); #1;
        start3 = 1'b1;
        begin : rand_sweep
            int c;
            bit got_done;
            c = 0;
            got_done = 1'b0;
            while (c < 4000) begin
                @(posedge clk); #1;
                start3 = (c == 50);
                pif3.pair_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (done3) begin
                    got_done = 1'b1;
                    break;
                end
                c++;
            end
            check_eq("done_rand_timeout", got_done, 1);
        end
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        check_eq("count_rand", n_hs3, 378);
        check_eq("queue_empty_rand", exp_q.size(), 0);
        @(negedge clk);
        check_eq("done_start_ignored", {busy3, done3, pif3.pair_valid}, 3'b000);
        @(negedge clk);
        check_eq("still_idle", {busy3, pif3.pair_valid}, 2'b00);

        // Asynchronous reset at pair 100, then a fresh sweep from (0,0).
        pif3.pair_ready = 1'b1;
        start_sweep3();
        begin : wait_100
            int c;
            c = 0;
            while (c < 1000 && n_hs3 < 100) begin
                @(posedge clk);
                c++;
            end
            check_eq("reach_100", n_hs3 >= 100, 1);
        end
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst", {pif3.pair_valid, busy3}, 2'b00);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        start_sweep3();
        wait_done3(1000);
        check_eq("count_restart", n_hs3, 378);
        check_eq("queue_empty_restart", exp_q.size(), 0);

        // U=5 sweep through the n3l acceptance model.
        pif5.pair_ready = 1'b1;
        n_hs5 = 0;
        @(posedge clk); #1;
        start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        begin : wait_u5
            int c;
            c = 0;
            while (c < 3000) begin
                @(negedge clk);
                if (done5) break;
                c++;
            end
            check_eq("done5_timeout", c < 3000, 1);
        end
        check_eq("count_u5", n_hs5, 1750);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
